// File: rtl/uc_sequencer_if.sv
// Bundle between the microprogram sequencer and its surroundings: control store,
// instruction register, ALU flags, memory handshake and the datapath controls.
interface uc_sequencer_if #(
   parameter int DATAWIDTH_BUS           = 32,
   parameter int DATAWIDTH_MIR_DIRECTION = 6,
   parameter int DATAWIDTH_ALU_SELECTION = 4,
   parameter int DATAWIDTH_CS_ADDRESS    = 11,
   parameter int DATAWIDTH_MICROWORD     = 41
);
   logic [DATAWIDTH_MICROWORD-1:0]     cs_data;
   logic [DATAWIDTH_BUS-1:0]           ir;
   logic                               flag_n;
   logic                               flag_z;
   logic                               flag_v;
   logic                               flag_c;
   logic                               set_code;
   logic                               mem_ready;
   logic [DATAWIDTH_CS_ADDRESS-1:0]    cs_address;
   logic [DATAWIDTH_MIR_DIRECTION-1:0] dir_a;
   logic [DATAWIDTH_MIR_DIRECTION-1:0] dir_b;
   logic [DATAWIDTH_MIR_DIRECTION-1:0] dir_c;
   logic                               select_a;
   logic                               select_b;
   logic                               select_c;
   logic [DATAWIDTH_ALU_SELECTION-1:0] alu_operation;
   logic                               rd;
   logic                               wr;
   logic [3:0]                         psr;
   logic                               error;

   modport master (
      input  cs_data, ir, flag_n, flag_z, flag_v, flag_c, set_code, mem_ready,
      output cs_address, dir_a, dir_b, dir_c, select_a, select_b, select_c,
             alu_operation, rd, wr, psr, error
   );

   modport slave (
      output cs_data, ir, flag_n, flag_z, flag_v, flag_c, set_code, mem_ready,
      input  cs_address, dir_a, dir_b, dir_c, select_a, select_b, select_c,
             alu_operation, rd, wr, psr, error
   );
endinterface

// File: rtl/uc_sequencer.sv
// Microprogram sequencer: fetches microwords into the MIR, drives the datapath from it,
// latches ALU flags into the PSR and computes the next control-store address.
module uc_sequencer #(
   parameter int DATAWIDTH_BUS           = 32,
   parameter int DATAWIDTH_MIR_DIRECTION = 6,
   parameter int DATAWIDTH_ALU_SELECTION = 4,
   parameter int DATAWIDTH_CS_ADDRESS    = 11,
   parameter int DATAWIDTH_MICROWORD     = 41,
   parameter int MEM_TIMEOUT             = 255,
   parameter logic [DATAWIDTH_CS_ADDRESS-1:0] TRAP_ADDRESS = 11'h7F0
) (
   input logic            clk,
   input logic            rst_n,
   uc_sequencer_if.master bus
);
   localparam int JUMP_LSB = 0;
   localparam int COND_LSB = JUMP_LSB + DATAWIDTH_CS_ADDRESS;
   localparam int ALU_LSB  = COND_LSB + 3;
   localparam int WR_BIT   = ALU_LSB + DATAWIDTH_ALU_SELECTION;
   localparam int RD_BIT   = WR_BIT + 1;
   localparam int CMUX_BIT = RD_BIT + 1;
   localparam int C_LSB    = CMUX_BIT + 1;
   localparam int BMUX_BIT = C_LSB + DATAWIDTH_MIR_DIRECTION;
   localparam int B_LSB    = BMUX_BIT + 1;
   localparam int AMUX_BIT = B_LSB + DATAWIDTH_MIR_DIRECTION;
   localparam int A_LSB    = AMUX_BIT + 1;
   localparam int WAIT_W   = $clog2(MEM_TIMEOUT + 1);

   localparam logic [1:0] FETCH    = 2'd0;
   localparam logic [1:0] EXECUTE  = 2'd1;
   localparam logic [1:0] WAIT_MEM = 2'd2;
   localparam logic [1:0] TRAP     = 2'd3;

   logic [1:0]                      state;
   logic [DATAWIDTH_MICROWORD-1:0]  mir;
   logic [DATAWIDTH_CS_ADDRESS-1:0] csai;
   logic [3:0]                      psr_q;
   logic [WAIT_W-1:0]               wait_count;
   logic                            error_q;

   logic                            active;
   logic                            mem_access;
   logic                            commit;
   logic                            branch_taken;
   logic [2:0]                      cond;
   logic [DATAWIDTH_CS_ADDRESS-1:0] jump;
   logic [DATAWIDTH_CS_ADDRESS-1:0] next_csai;

   assign cond       = mir[COND_LSB +: 3];
   assign jump       = mir[JUMP_LSB +: DATAWIDTH_CS_ADDRESS];
   assign active     = (state == EXECUTE) || (state == WAIT_MEM);
   assign mem_access = mir[RD_BIT] | mir[WR_BIT];
   assign commit     = active && (!mem_access || bus.mem_ready);

   // Branches look at the PSR as registered, so a flag update in the same commit
   // only becomes visible to the following microinstruction.
   always_comb begin
      branch_taken = 1'b0;
      case (cond)
         3'b001:  branch_taken = psr_q[3];
         3'b010:  branch_taken = psr_q[2];
         3'b011:  branch_taken = psr_q[1];
         3'b100:  branch_taken = psr_q[0];
         3'b101:  branch_taken = bus.ir[13];
         3'b110:  branch_taken = 1'b1;
         default: branch_taken = 1'b0;
      endcase
      if (cond == 3'b111)
         next_csai = {1'b1, bus.ir[DATAWIDTH_BUS-1 -: 2], bus.ir[24:19], 2'b00};
      else if (branch_taken)
         next_csai = jump;
      else
         next_csai = csai + DATAWIDTH_CS_ADDRESS'(1);
   end

   // The C write is steered to r0 until the microinstruction actually commits.
   assign bus.dir_a         = mir[A_LSB +: DATAWIDTH_MIR_DIRECTION];
   assign bus.select_a      = mir[AMUX_BIT];
   assign bus.dir_b         = mir[B_LSB +: DATAWIDTH_MIR_DIRECTION];
   assign bus.select_b      = mir[BMUX_BIT];
   assign bus.dir_c         = commit ? mir[C_LSB +: DATAWIDTH_MIR_DIRECTION] : '0;
   assign bus.select_c      = commit ? mir[CMUX_BIT] : 1'b0;
   assign bus.alu_operation = mir[ALU_LSB +: DATAWIDTH_ALU_SELECTION];
   assign bus.rd            = active & mir[RD_BIT];
   assign bus.wr            = active & mir[WR_BIT];
   assign bus.cs_address    = csai;
   assign bus.psr           = psr_q;
   assign bus.error         = error_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FETCH;
         mir        <= '0;
         csai       <= '0;
         psr_q      <= '0;
         wait_count <= '0;
         error_q    <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               mir   <= bus.cs_data;
               state <= EXECUTE;
            end
            EXECUTE, WAIT_MEM: begin
               if (commit) begin
                  csai       <= next_csai;
                  wait_count <= '0;
                  state      <= FETCH;
                  if (bus.set_code)
                     psr_q <= {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c};
               end else if (state == EXECUTE) begin
                  wait_count <= WAIT_W'(1);
                  state      <= WAIT_MEM;
               end else if (wait_count == WAIT_W'(MEM_TIMEOUT)) begin
                  wait_count <= '0;
                  state      <= TRAP;
               end else begin
                  wait_count <= wait_count + WAIT_W'(1);
               end
            end
            TRAP: begin
               error_q <= 1'b1;
               csai    <= TRAP_ADDRESS;
               state   <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_uc_sequencer.sv
// Self-checking bench for uc_sequencer: vector table, hand-written multi-cycle cases
// and randomized microprograms compared against a per-microinstruction model.
module tb_uc_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uc_sequencer_if bus ();
   uc_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [40:0] cs_mem [0:2047];
   assign bus.cs_data = cs_mem[bus.cs_address];

   int tests_run    = 0;
   int tests_failed = 0;

   logic [10:0] exp_pc;
   logic [3:0]  exp_psr;
   logic        exp_err;

   typedef struct {
      logic [3:0]  flags;
      logic [2:0]  cond;
      logic [10:0] jump;
      logic [31:0] ir;
      logic [10:0] expected;
   } vec_t;
   vec_t vecs [13];

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [40:0] mkWord(input logic [5:0] a, input logic am, input logic [5:0] b,
                                          input logic bm, input logic [5:0] c, input logic cm,
                                          input logic rd, input logic wr, input logic [3:0] alu,
                                          input logic [2:0] cond, input logic [10:0] jump);
      return {a, am, b, bm, c, cm, rd, wr, alu, cond, jump};
   endfunction

   // Next address from the branch rules, using plain integer arithmetic.
   function automatic logic [10:0] modelNext(input logic [40:0] w, input logic [3:0] psr,
                                             input logic [31:0] ir, input logic [10:0] pc);
      int seq;
      int target;
      logic taken;
      seq    = (int'(pc) + 1) % 2048;
      target = int'(w[10:0]);
      taken  = 1'b0;
      case (w[13:11])
         3'd1: taken = psr[3];
         3'd2: taken = psr[2];
         3'd3: taken = psr[1];
         3'd4: taken = psr[0];
         3'd5: taken = ir[13];
         3'd6: taken = 1'b1;
         3'd7: return 11'(1024 + int'(ir[31:30]) * 256 + int'(ir[24:19]) * 4);
         default: taken = 1'b0;
      endcase
      return taken ? 11'(target) : 11'(seq);
   endfunction

   task automatic driveNoise();
      bus.set_code = 1'($urandom);
      {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} = 4'($urandom);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_csaddr", bus.cs_address, 0);
      checkOutput("rst_psr", bus.psr, 0);
      checkOutput("rst_error", bus.error, 0);
      checkOutput("rst_rdwr", {bus.rd, bus.wr}, 0);
      checkOutput("rst_dirs", {bus.dir_a, bus.dir_b, bus.dir_c}, 0);
      checkOutput("rst_sel_alu", {bus.select_a, bus.select_b, bus.select_c, bus.alu_operation}, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      exp_pc  = '0;
      exp_psr = '0;
      exp_err = 1'b0;
   endtask

   // Runs one microinstruction from its FETCH cycle; k = cycles memory stays not-ready.
   task automatic applyStimulus(input logic [40:0] word, input int k, input logic [3:0] cflags,
                                input logic csc, input logic [31:0] ir);
      logic access;
      logic commit;
      access = word[19] | word[18];
      cs_mem[exp_pc] = word;
      @(negedge clk);
      bus.ir = ir;
      bus.mem_ready = 1'($urandom);
      driveNoise();
      #1;
      checkOutput("fetch_csaddr", bus.cs_address, exp_pc);
      checkOutput("fetch_psr", bus.psr, exp_psr);
      checkOutput("fetch_error", bus.error, exp_err);
      checkOutput("fetch_rdwr", {bus.rd, bus.wr}, 0);
      checkOutput("fetch_dirc", bus.dir_c, 0);
      for (int i = 0; i <= 256; i++) begin
         @(negedge clk);
         if (access && i == 256) begin
            driveNoise();
            #1;
            checkOutput("trap_rdwr", {bus.rd, bus.wr}, 0);
            checkOutput("trap_dirc", bus.dir_c, 0);
            exp_pc  = 11'h7F0;
            exp_err = 1'b1;
            break;
         end
         commit = !access || (i == k);
         bus.mem_ready = access ? (i >= k) : 1'($urandom);
         if (commit) begin
            bus.set_code = csc;
            {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} = cflags;
         end else begin
            driveNoise();
         end
         #1;
         checkOutput("exec_rdwr", {bus.rd, bus.wr}, {word[19], word[18]});
         checkOutput("exec_dira", {bus.select_a, bus.dir_a}, {word[34], word[40:35]});
         checkOutput("exec_dirb", {bus.select_b, bus.dir_b}, {word[27], word[33:28]});
         checkOutput("exec_alu", bus.alu_operation, word[17:14]);
         checkOutput("exec_dirc", bus.dir_c, commit ? word[26:21] : 6'd0);
         if (commit) begin
            exp_pc = modelNext(word, exp_psr, ir, exp_pc);
            if (csc) exp_psr = cflags;
            break;
         end
      end
   endtask

   initial begin
      int seq_b [5];
      logic [40:0] w;
      rst_n = 1'b0;
      bus.ir = '0;
      bus.mem_ready = 1'b0;
      bus.set_code = 1'b0;
      {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} = 4'd0;
      for (int i = 0; i < 2048; i++) cs_mem[i] = '0;

      vecs[0]  = '{4'b0000, 3'b000, 11'h3AA, 32'h0000_0000, 11'd2};
      vecs[1]  = '{4'b0100, 3'b010, 11'h123, 32'h0000_0000, 11'h123};
      vecs[2]  = '{4'b0000, 3'b010, 11'h123, 32'h0000_0000, 11'd2};
      vecs[3]  = '{4'b1000, 3'b001, 11'h222, 32'h0000_0000, 11'h222};
      vecs[4]  = '{4'b0111, 3'b001, 11'h222, 32'h0000_0000, 11'd2};
      vecs[5]  = '{4'b0010, 3'b011, 11'h444, 32'h0000_0000, 11'h444};
      vecs[6]  = '{4'b0001, 3'b100, 11'h555, 32'h0000_0000, 11'h555};
      vecs[7]  = '{4'b1110, 3'b100, 11'h555, 32'h0000_0000, 11'd2};
      vecs[8]  = '{4'b0000, 3'b101, 11'h666, 32'h0000_2000, 11'h666};
      vecs[9]  = '{4'b1111, 3'b101, 11'h666, 32'hFFFF_DFFF, 11'd2};
      vecs[10] = '{4'b0000, 3'b110, 11'h050, 32'h0000_0000, 11'h050};
      vecs[11] = '{4'b0000, 3'b111, 11'h001, 32'h8080_0000, 11'd1600};
      vecs[12] = '{4'b0000, 3'b111, 11'h001, 32'hFFFF_FFFF, 11'h7FC};

      doReset();

      // Flags loaded by a setup word at 0, then the branch word at 1 is judged.
      for (int i = 0; i < 13; i++) begin
         doReset();
         applyStimulus(mkWord(6'd1, 1'b0, 6'd2, 1'b0, 6'd3, 1'b0, 1'b0, 1'b0, 4'd5, 3'b000, 11'd0),
                       0, vecs[i].flags, 1'b1, 32'd0);
         applyStimulus(mkWord(6'd4, 1'b1, 6'd5, 1'b1, 6'd6, 1'b1, 1'b0, 1'b0, 4'd9, vecs[i].cond, vecs[i].jump),
                       0, 4'($urandom), 1'b0, vecs[i].ir);
         @(negedge clk);
         #1;
         checkOutput("vec_csaddr", bus.cs_address, vecs[i].expected);
      end

      // Two back-to-back microinstructions, two cycles each.
      doReset();
      cs_mem[0] = mkWord(6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b0, 1'b0, 1'b0, 4'd0, 3'b000, 11'd0);
      cs_mem[1] = mkWord(6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b0, 1'b0, 1'b0, 4'd0, 3'b110, 11'h050);
      bus.mem_ready = 1'b1;
      bus.set_code = 1'b0;
      seq_b = '{0, 0, 1, 1, 'h50};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checkOutput("seq_csaddr", bus.cs_address, seq_b[i]);
      end

      // Reset in the middle of a stalled read.
      doReset();
      applyStimulus(mkWord(6'd1, 1'b0, 6'd1, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 4'd1, 3'b000, 11'd0),
                    0, 4'hF, 1'b1, 32'd0);
      cs_mem[1] = mkWord(6'd9, 1'b1, 6'd9, 1'b1, 6'd9, 1'b1, 1'b1, 1'b0, 4'd3, 3'b000, 11'd0);
      bus.mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("stall_rd", bus.rd, 1);
      doReset();
      applyStimulus(mkWord(6'd2, 1'b0, 6'd3, 1'b0, 6'd4, 1'b0, 1'b1, 1'b0, 4'd2, 3'b000, 11'd0),
                    0, 4'h0, 1'b0, 32'd0);

      // Memory not ready for 3 cycles, then ready right at the timeout limit.
      applyStimulus(mkWord(6'd5, 1'b0, 6'd6, 1'b0, 6'd21, 1'b1, 1'b1, 1'b0, 4'd4, 3'b000, 11'd0),
                    3, 4'b0101, 1'b1, 32'd0);
      applyStimulus(mkWord(6'd5, 1'b0, 6'd6, 1'b0, 6'd22, 1'b0, 1'b0, 1'b1, 4'd4, 3'b000, 11'd0),
                    255, 4'b1010, 1'b1, 32'd0);

      // Timeout trap, sticky error, then 0x7FF wraps to 0.
      applyStimulus(mkWord(6'd7, 1'b0, 6'd8, 1'b0, 6'd9, 1'b0, 1'b1, 1'b0, 4'd6, 3'b000, 11'd0),
                    1000, 4'hF, 1'b1, 32'd0);
      applyStimulus(mkWord(6'd1, 1'b0, 6'd1, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 4'd1, 3'b110, 11'h7FF),
                    0, 4'h0, 1'b0, 32'd0);
      applyStimulus(mkWord(6'd1, 1'b0, 6'd1, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 4'd1, 3'b000, 11'd0),
                    0, 4'h0, 1'b0, 32'd0);
      applyStimulus(mkWord(6'd1, 1'b0, 6'd1, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 4'd1, 3'b000, 11'd0),
                    0, 4'h0, 1'b0, 32'd0);
      doReset();

      // Random microprograms.
      for (int n = 0; n < 200; n++) begin
         w = 41'({$urandom, $urandom});
         if ($urandom_range(0, 1) == 0) w[19:18] = 2'b00;
         applyStimulus(w, $urandom_range(0, 4), 4'($urandom), 1'($urandom), $urandom);
      end
      @(negedge clk);
      #1;
      checkOutput("final_csaddr", bus.cs_address, exp_pc);
      checkOutput("final_psr", bus.psr, exp_psr);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
